// File: rtl/instr_encoder_if.sv
// Handshake bundle for the streaming MIPS instruction encoder.
// master drives symbolic instructions and consumes words; slave is the encoder.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [25:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic [7:0]        err_count;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err, err_count
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err, err_count
    );
endinterface

// File: rtl/instr_encoder.sv
// Streaming MIPS encoder: symbolic instruction -> 32-bit word, queued with its imem byte address.
// All bus outputs are registered; the output registers always mirror the FIFO head.
module instr_encoder #(
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input logic            clk,
    input logic            reset,
    instr_encoder_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [3:0] K_ADD  = 4'd0;
    localparam logic [3:0] K_SUB  = 4'd1;
    localparam logic [3:0] K_SLT  = 4'd2;
    localparam logic [3:0] K_JR   = 4'd3;
    localparam logic [3:0] K_LW   = 4'd4;
    localparam logic [3:0] K_SW   = 4'd5;
    localparam logic [3:0] K_J    = 4'd6;
    localparam logic [3:0] K_JAL  = 4'd7;
    localparam logic [3:0] K_BNE  = 4'd8;
    localparam logic [3:0] K_XORI = 4'd9;

    logic [31:0]       mem_instr [DEPTH];
    logic [ADDR_W-1:0] mem_addr  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_n;
    logic [CNT_W-1:0]  count, count_n;
    logic [ADDR_W-1:0] wr_addr;

    logic              ready_q, valid_q, err_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        err_cnt_q;

    logic [31:0]       word;
    logic              legal, accept, push, pop;
    logic [31:0]       head_instr;
    logic [ADDR_W-1:0] head_addr;

    // Field packing; kinds 10-15 leave legal low and are dropped.
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (bus.in_kind)
            K_ADD:  begin legal = 1'b1; word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'b100000}; end
            K_SUB:  begin legal = 1'b1; word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'b100010}; end
            K_SLT:  begin legal = 1'b1; word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'b101010}; end
            K_JR:   begin legal = 1'b1; word = {6'b000000, bus.in_rs, 15'b0, 6'b001000}; end
            K_LW:   begin legal = 1'b1; word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm[15:0]}; end
            K_SW:   begin legal = 1'b1; word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm[15:0]}; end
            K_BNE:  begin legal = 1'b1; word = {6'b000101, bus.in_rs, bus.in_rt, bus.in_imm[15:0]}; end
            K_XORI: begin legal = 1'b1; word = {6'b001110, bus.in_rs, bus.in_rt, bus.in_imm[15:0]}; end
            K_J:    begin legal = 1'b1; word = {6'b000010, bus.in_imm}; end
            K_JAL:  begin legal = 1'b1; word = {6'b000011, bus.in_imm}; end
            default: ;
        endcase
    end

    // Handshake decode and the head the output registers will hold after this edge.
    always_comb begin
        accept   = bus.in_valid & ready_q;
        push     = accept & legal;
        pop      = valid_q & bus.out_ready;
        rd_ptr_n = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        case ({push, pop})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
        endcase
        head_instr = mem_instr[rd_ptr_n];
        head_addr  = mem_addr[rd_ptr_n];
        // Pushing into an (about to be) empty FIFO: new word becomes head immediately.
        if (push && (wr_ptr == rd_ptr_n)) begin
            head_instr = word;
            head_addr  = wr_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= word;
            mem_addr[wr_ptr]  <= wr_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_addr   <= BASE_ADDR;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            instr_q   <= '0;
            addr_q    <= BASE_ADDR;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            rd_ptr  <= rd_ptr_n;
            count   <= count_n;
            ready_q <= (count_n != CNT_W'(DEPTH));
            valid_q <= (count_n != '0);
            if (push) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                wr_addr <= wr_addr + ADDR_W'(4);
            end
            if (count_n != '0) begin
                instr_q <= head_instr;
                addr_q  <= head_addr;
            end
            err_q <= accept & ~legal;
            if (accept && !legal && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_addr  = addr_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_cnt_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized + directed bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } entry_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Reference model state
    entry_t      q[$];
    logic [31:0] m_addr;
    logic [31:0] m_instr;
    logic [31:0] m_oaddr;
    bit          m_rdy;
    bit          m_err;
    int          m_errcnt;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Encoding computed as field_value * 2^position sums from the ISA tables.
    function automatic bit ref_encode(input int kind, input int rs, input int rt, input int rd,
                                      input int imm, output logic [31:0] w);
        int op_of [10] = '{0, 0, 0, 0, 35, 43, 2, 3, 5, 14};
        int fn_of [4]  = '{32, 34, 42, 8};
        longint v;
        w = '0;
        if (kind < 0 || kind > 9) return 1'b0;
        if (kind <= 2)
            v = longint'(rs) * (64'd1 << 21) + longint'(rt) * (64'd1 << 16)
              + longint'(rd) * (64'd1 << 11) + longint'(fn_of[kind]);
        else if (kind == 3)
            v = longint'(rs) * (64'd1 << 21) + longint'(fn_of[3]);
        else if (kind == 6 || kind == 7)
            v = longint'(op_of[kind]) * (64'd1 << 26) + longint'(imm) % (64'd1 << 26);
        else
            v = longint'(op_of[kind]) * (64'd1 << 26) + longint'(rs) * (64'd1 << 21)
              + longint'(rt) * (64'd1 << 16) + longint'(imm) % 65536;
        w = 32'(v);
        return 1'b1;
    endfunction

    // One clock: drive at negedge, advance model, compare all outputs at next negedge.
    task automatic cycle(input bit r, input bit v, input int k, input int rs, input int rt,
                         input int rd, input int imm, input bit ordy);
        logic [31:0] w;
        bit legal, acc, pop;
        reset         = r;
        bus.in_valid  = v;
        bus.in_kind   = 4'(k);
        bus.in_rs     = 5'(rs);
        bus.in_rt     = 5'(rt);
        bus.in_rd     = 5'(rd);
        bus.in_imm    = 26'(imm);
        bus.out_ready = ordy;
        legal = ref_encode(k, rs, rt, rd, imm, w);
        if (r) begin
            q.delete();
            m_addr   = BASE;
            m_rdy    = 1'b0;
            m_instr  = '0;
            m_oaddr  = BASE;
            m_err    = 1'b0;
            m_errcnt = 0;
        end else begin
            acc = v && m_rdy;
            pop = (q.size() != 0) && ordy;
            if (pop) q.delete(0);
            if (acc && legal) begin
                q.push_back('{w, m_addr});
                m_addr = m_addr + 32'd4;
            end
            m_err = acc && !legal;
            if (m_err && m_errcnt < 255) m_errcnt++;
            m_rdy = (q.size() != DEPTH);
            if (q.size() != 0) begin
                m_instr = q[0].instr;
                m_oaddr = q[0].addr;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_val("in_ready",  64'(bus.in_ready),  64'(m_rdy));
        check_val("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        check_val("out_instr", 64'(bus.out_instr), 64'(m_instr));
        check_val("out_addr",  64'(bus.out_addr),  64'(m_oaddr));
        check_val("err",       64'(bus.err),       64'(m_err));
        check_val("err_count", 64'(bus.err_count), 64'(m_errcnt));
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 1'b0, 0, 0, 0, 0, 0, ordy);
    endtask

    task automatic push(input int k, input int rs, input int rt, input int rd, input int imm,
                        input bit ordy);
        cycle(1'b0, 1'b1, k, rs, rt, rd, imm, ordy);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        check_val("reset_in_ready", 64'(bus.in_ready), 64'd0);
        cycle(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        idle(1'b0);
    endtask

    initial begin
        int exp_a;
        int popped;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_kind   = '0;
        bus.in_rs     = '0;
        bus.in_rt     = '0;
        bus.in_rd     = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        // ADD with downstream ready
        do_reset();
        check_val("rst_out_instr", 64'(bus.out_instr), 64'd0);
        check_val("rst_out_addr",  64'(bus.out_addr),  64'(BASE));
        push(0, 1, 2, 3, 0, 1'b1);
        check_val("add_word",  64'(bus.out_instr), 64'h00221820);
        check_val("add_addr",  64'(bus.out_addr),  64'h0);
        check_val("add_valid", 64'(bus.out_valid), 64'd1);

        // LW then J
        do_reset();
        push(4, 29, 8, 0, 32'hFFFC, 1'b0);
        push(6, 0, 0, 0, 32'h10, 1'b0);
        check_val("lw_word", 64'(bus.out_instr), 64'h8FA8FFFC);
        check_val("lw_addr", 64'(bus.out_addr),  64'h0);
        idle(1'b1);
        check_val("j_word", 64'(bus.out_instr), 64'h08000010);
        check_val("j_addr", 64'(bus.out_addr),  64'h4);
        idle(1'b1);

        // Fill, stall fifth, release
        do_reset();
        for (int i = 0; i < 4; i++) push(0, 1, 2, i, 0, 1'b0);
        check_val("full_ready", 64'(bus.in_ready), 64'd0);
        push(1, 4, 5, 6, 0, 1'b0);
        check_val("stall_addr", 64'(bus.out_addr), 64'h0);
        push(1, 4, 5, 6, 0, 1'b1);
        push(1, 4, 5, 6, 0, 1'b0);
        exp_a = 4;
        for (int i = 0; i < 10 && bus.out_valid; i++) begin
            check_val("drain_addr", 64'(bus.out_addr), 64'(exp_a));
            exp_a += 4;
            idle(1'b1);
        end
        check_val("drain_last_addr", 64'(exp_a), 64'd20);

        // Illegal kind between two SUBs
        do_reset();
        push(1, 1, 2, 3, 0, 1'b0);
        push(12, 7, 7, 7, 0, 1'b0);
        check_val("illegal_err", 64'(bus.err), 64'd1);
        check_val("illegal_cnt", 64'(bus.err_count), 64'd1);
        push(1, 3, 2, 1, 0, 1'b0);
        check_val("err_pulse_end", 64'(bus.err), 64'd0);
        check_val("sub0_addr", 64'(bus.out_addr), 64'h0);
        idle(1'b1);
        check_val("sub1_addr", 64'(bus.out_addr), 64'h4);
        idle(1'b1);

        // Full FIFO with simultaneous pop and in_valid: pop only
        do_reset();
        for (int i = 0; i < 4; i++) push(2, i, i, i, 0, 1'b0);
        push(2, 9, 9, 9, 0, 1'b1);
        check_val("fullpop_ready", 64'(bus.in_ready), 64'd1);
        popped = 0;
        for (int i = 0; i < 10 && bus.out_valid; i++) begin
            popped++;
            idle(1'b1);
        end
        check_val("fullpop_count", 64'(popped), 64'd3);

        // Reset with queued words
        do_reset();
        for (int i = 0; i < 3; i++) push(5, i, i, 0, i, 1'b0);
        cycle(1'b1, 1'b1, 0, 1, 1, 1, 0, 1'b0);
        check_val("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        idle(1'b0);
        push(9, 3, 4, 0, 32'h1234, 1'b0);
        check_val("post_rst_addr", 64'(bus.out_addr), 64'(BASE));
        check_val("post_rst_valid", 64'(bus.out_valid), 64'd1);

        // err_count saturation
        do_reset();
        for (int i = 0; i < 260; i++) push(10 + (i % 6), 0, 0, 0, 0, 1'b1);
        check_val("err_sat", 64'(bus.err_count), 64'd255);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int k;
            k = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, k,
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom & 32'h03FF_FFFF),
                  $urandom_range(0, 2) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
